// File: rtl/shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mul_ctrl
//  Purpose  : Sequential unsigned WIDTH x WIDTH multiplier. One partial-product
//             row (A AND a replicated bit of B) is shifted and accumulated per
//             clock into a 2*WIDTH product. Operands come in through a
//             valid/ready start handshake; the product leaves through a
//             valid/ready result handshake.
//  Ports    :
//    clk          in   1          system clock (rising edge)
//    rst          in   1          synchronous active-high reset
//    start_valid  in   1          requester presents operands a, b
//    start_ready  out  1          controller can accept operands (IDLE)
//    a            in   WIDTH      multiplicand, sampled on accept edge only
//    b            in   WIDTH      multiplier, sampled on accept edge only
//    res_valid    out  1          product valid and stable (DONE)
//    res_ready    in   1          consumer accepts product
//    product      out  2*WIDTH    unsigned a*b
//    busy         out  1          high in RUN or DONE
//    step         out  clog2(WIDTH)+1  current row index, 0 outside RUN
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_mul_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [2*WIDTH-1:0]         product,
    output logic                       busy,
    output logic [$clog2(WIDTH):0]     step
);

    localparam int SW = $clog2(WIDTH) + 1;
    localparam logic [SW-1:0] c_last_step = SW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic [SW-1:0]        r_step;

    logic [WIDTH-1:0]     w_bsel;
    logic                 w_bit;
    logic [2*WIDTH-1:0]   w_row;
    logic [2*WIDTH-1:0]   w_sum;

    // Select B_reg[step] with a variable shift so the index width never has
    // to match the operand width exactly.
    assign w_bsel = r_b >> r_step;
    assign w_bit  = w_bsel[0];
    assign w_row  = {{WIDTH{1'b0}}, (r_a & {WIDTH{w_bit}})} << r_step;
    assign w_sum  = r_acc + w_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_step    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= '0;
                        r_step  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_sum;
                    // Fixed WIDTH iterations; zero rows are still walked so
                    // latency is independent of the operand values.
                    if (r_step == c_last_step) begin
                        r_product <= w_sum;
                        r_step    <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_step    <= r_step + SW'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign start_ready = (r_state == S_IDLE);
    assign res_valid   = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign product     = r_product;
    assign step        = r_step;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mul_ctrl
//  Purpose  : Self-checking bench for shift_add_mul_ctrl. Directed and random
//             operations compared against a plain a*b reference with cycle
//             accurate handshake expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_add_mul_ctrl;

    localparam int W  = 4;
    localparam int SW = $clog2(W) + 1;

    logic            clk;
    logic            rst;
    logic            start_valid;
    logic            start_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            res_valid;
    logic            res_ready;
    logic [2*W-1:0]  product;
    logic            busy;
    logic [SW-1:0]   step;

    int checks   = 0;
    int failures = 0;

    shift_add_mul_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .product     (product),
        .busy        (busy),
        .step        (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full operation: accept, WIDTH RUN cycles, optional backpressure of
    // 'hold' cycles in DONE, then result acceptance. Inputs change on negedge.
    task automatic do_op(input int av, input int bv, input int hold, input bit scramble);
        int exp;
        exp = (av * bv) % (1 << (2 * W));
        @(negedge clk);
        chk("idle_start_ready", start_ready, 1);
        chk("idle_res_valid", res_valid, 0);
        a           = W'(av);
        b           = W'(bv);
        start_valid = 1'b1;
        res_ready   = (hold == 0);
        @(negedge clk);                       // accept edge has passed
        start_valid = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_start_ready", start_ready, 0);
        for (int k = 0; k < W; k++) begin
            if (k > 0) @(negedge clk);
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
                start_valid = 1'($urandom);
            end
            chk("run_step", step, k);
            chk("run_res_valid", res_valid, 0);
        end
        start_valid = 1'b0;
        @(negedge clk);                       // WIDTH edges after accept
        chk("done_res_valid", res_valid, 1);
        chk("done_product", product, exp);
        chk("done_step", step, 0);
        chk("done_busy", busy, 1);
        for (int h = 0; h < hold; h++) begin
            a           = W'($urandom);
            b           = W'($urandom);
            start_valid = 1'($urandom);
            @(negedge clk);
            chk("bp_res_valid", res_valid, 1);
            chk("bp_product", product, exp);
            chk("bp_start_ready", start_ready, 0);
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(negedge clk);                       // result accepted
        chk("post_res_valid", res_valid, 0);
        chk("post_start_ready", start_ready, 1);
        chk("post_busy", busy, 0);
        res_ready = 1'b0;
    endtask

    initial begin
        int last_acc;
        int n_acc;
        int cyc;

        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step", step, 0);
        chk("rst_product", product, 0);

        // Directed cases
        do_op(13, 11, 0, 1'b0);
        do_op(15, 15, 0, 1'b0);
        do_op(0, 9, 0, 1'b0);
        do_op(7, 0, 0, 1'b0);
        do_op(6, 5, 6, 1'b0);
        do_op(9, 3, 0, 1'b1);

        // Reset mid-RUN at step 2
        @(negedge clk);
        a = 4'd11; b = 4'd13; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_step2", step, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_step", step, 0);
        chk("midrst_start_ready", start_ready, 1);
        chk("midrst_busy", busy, 0);
        do_op(2, 3, 0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            do_op(int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Back-to-back with start_valid held high
        @(negedge clk);
        a = 4'd3; b = 4'd4; start_valid = 1'b1; res_ready = 1'b1;
        last_acc = -1; n_acc = 0; cyc = 0;
        while (n_acc < 4 && cyc < 200) begin
            if (res_valid) chk("b2b_product", product, 12);
            if (start_ready) begin
                if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, W + 2);
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b_accepts", n_acc, 4);
        start_valid = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
